// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce.
// Emits one-cycle key events and keeps the last four codes for the display.
//
// state        | meaning
// ST_RELEASED  | no key accepted; waiting for a stable single-key frame
// ST_HELD      | a key was accepted; waiting for stable all-released frames
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  input  logic        msg_clr,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] msg
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_ONE, RES_MULTI} res_e;
  typedef enum logic {ST_RELEASED, ST_HELD} state_e;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic          res_vld_q, res_vld_d;
  res_e          res_kind_q, res_kind_d;
  logic [3:0]    res_code_q, res_code_d;
  res_e          prev_kind_q, prev_kind_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic [CW-1:0] stab_cnt_q, stab_cnt_d;
  state_e        state_q, state_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic [15:0]   msg_q, msg_d;

  logic          sample;
  logic [2:0]    col_hits;
  logic [3:0]    col_code;
  logic [2:0]    sum;
  logic [3:0]    sel_code;
  logic          stable;
  logic          accept;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    case ({c, r})
      4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
      4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
      4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
      4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'h0;
      res_vld_q   <= 1'b0;
      res_kind_q  <= RES_NONE;
      res_code_q  <= 4'h0;
      prev_kind_q <= RES_NONE;
      prev_code_q <= 4'h0;
      stab_cnt_q  <= '0;
      state_q     <= ST_RELEASED;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      msg_q       <= 16'h0000;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      res_vld_q   <= res_vld_d;
      res_kind_q  <= res_kind_d;
      res_code_q  <= res_code_d;
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      stab_cnt_q  <= stab_cnt_d;
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      msg_q       <= msg_d;
    end
  end

  // Scan, per-column sampling and frame accumulation.
  always_comb begin
    sample     = (dwell_q == DWELL_LAST);
    col_hits   = 3'd0;
    col_code   = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_map(col_idx_q, 2'(r));
      end
    end
    sum        = {1'b0, acc_cnt_q} + col_hits;
    sel_code   = (col_hits != 3'd0) ? col_code : acc_code_q;

    dwell_d    = dwell_q + DW'(1);
    col_idx_d  = col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    res_vld_d  = 1'b0;
    res_kind_d = res_kind_q;
    res_code_d = res_code_q;

    if (sample) begin
      dwell_d   = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (col_idx_q == 2'd3) begin
        res_vld_d  = 1'b1;
        res_kind_d = (sum == 3'd0) ? RES_NONE : (sum == 3'd1) ? RES_ONE : RES_MULTI;
        res_code_d = (sum == 3'd1) ? sel_code : 4'h0;
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'h0;
      end else begin
        acc_cnt_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        acc_code_d = sel_code;
      end
    end
  end

  // Stability counting and press/release FSM, evaluated once per frame result.
  always_comb begin
    prev_kind_d = prev_kind_q;
    prev_code_d = prev_code_q;
    stab_cnt_d  = stab_cnt_q;
    state_d     = state_q;
    stable      = 1'b0;
    accept      = 1'b0;

    if (res_vld_q) begin
      prev_kind_d = res_kind_q;
      prev_code_d = res_code_q;
      if (res_kind_q == RES_MULTI) begin
        stab_cnt_d = '0;
      end else if (res_kind_q == prev_kind_q && res_code_q == prev_code_q) begin
        stab_cnt_d = (stab_cnt_q == CNT_MAX) ? CNT_MAX : stab_cnt_q + CW'(1);
      end else begin
        stab_cnt_d = CW'(1);
      end
      stable = (res_kind_q != RES_MULTI) && (stab_cnt_d == CNT_MAX);

      case (state_q)
        ST_RELEASED: begin
          if (stable && res_kind_q == RES_ONE) begin
            state_d = ST_HELD;
            accept  = 1'b1;
          end
        end
        default: begin
          if (stable && res_kind_q == RES_NONE) state_d = ST_RELEASED;
        end
      endcase
    end

    key_valid_d = accept;
    key_code_d  = accept ? res_code_q : key_code_q;
    if (msg_clr) msg_d = accept ? {12'h000, res_code_q} : 16'h0000;
    else         msg_d = accept ? {msg_q[11:0], res_code_q} : msg_q;
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign msg       = msg_q;

endmodule
